// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - packed-BCD hh:mm:ss countdown timer with alarm
module bcd_countdown_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_hour,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       ack,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [1:0] state;
    logic       load_ok;
    logic       is_zero;
    logic       expiring;
    logic [8:0] sec_dec;
    logic [8:0] min_dec;
    logic [8:0] hour_dec;

    // Returns {borrow, next}: a 00 field wraps to the given value and borrows upward.
    function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
        logic [8:0] r;
        if (v == 8'h00) begin
            r = {1'b1, wrap};
        end else if (v[3:0] != 4'd0) begin
            r = {1'b0, v[7:4], v[3:0] - 4'd1};
        end else begin
            r = {1'b0, v[7:4] - 4'd1, 4'h9};
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

    always_comb begin
        load_ok  = bcd_ok(load_hour, 8'h23) && bcd_ok(load_min, 8'h59) && bcd_ok(load_sec, 8'h59);
        is_zero  = (hour == 8'h00) && (min == 8'h00) && (sec == 8'h00);
        expiring = (hour == 8'h00) && (min == 8'h00) && (sec == 8'h01);
        sec_dec  = bcd_dec(sec, 8'h59);
        min_dec  = sec_dec[8] ? bcd_dec(min, 8'h59) : {1'b0, min};
        // Hour never borrows from 00 here: a zero value is never counted in RUN.
        hour_dec = min_dec[8] ? bcd_dec(hour, 8'h00) : {1'b0, hour};
    end

    assign running = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            hour     <= 8'h00;
            min      <= 8'h00;
            sec      <= 8'h00;
            done     <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    hour  <= load_hour;
                    min   <= load_min;
                    sec   <= load_sec;
                    state <= ST_IDLE;
                    alarm <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (start || pause) begin
                // Any start/pause strobe suppresses that cycle's tick, even if ignored.
                if (start && !pause && (state == ST_IDLE || state == ST_PAUSED) && !is_zero) begin
                    state <= ST_RUN;
                end else if (pause && !start && state == ST_RUN) begin
                    state <= ST_PAUSED;
                end
            end else if (ack && state == ST_EXPIRED) begin
                state <= ST_IDLE;
                alarm <= 1'b0;
            end else if (tick && state == ST_RUN && !is_zero) begin
                hour <= hour_dec[7:0];
                min  <= min_dec[7:0];
                sec  <= sec_dec[7:0];
                if (expiring) begin
                    state <= ST_EXPIRED;
                    done  <= 1'b1;
                    alarm <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - directed self-checking bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, load, start, pause, ack;
    logic [7:0] load_hour, load_min, load_sec;
    logic [7:0] hour, min, sec;
    logic       running, done, alarm, load_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .load_hour (load_hour),
        .load_min  (load_min),
        .load_sec  (load_sec),
        .start     (start),
        .pause     (pause),
        .ack       (ack),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .running   (running),
        .done      (done),
        .alarm     (alarm),
        .load_err  (load_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given strobes; outputs are then sampled at the negedge.
    task automatic step(input logic ld, input logic st, input logic pa, input logic ak, input logic tk);
        load = ld; start = st; pause = pa; ack = ak; tick = tk;
        @(negedge clk);
        load = 0; start = 0; pause = 0; ack = 0; tick = 0;
    endtask

    task automatic preset(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        load_hour = h; load_min = m; load_sec = s;
        step(1, 0, 0, 0, 0);
    endtask

    function automatic logic [23:0] t();
        return {hour, min, sec};
    endfunction

    initial begin
        reset = 0; tick = 0; load = 0; start = 0; pause = 0; ack = 0;
        load_hour = 8'h11; load_min = 8'h22; load_sec = 8'h33;
        @(negedge clk);
        @(negedge clk);
        check("rst_time", t(), 24'h000000);
        check("rst_flags", {running, done, alarm, load_err}, 4'b0000);
        reset = 1;

        // basic expiry
        preset(8'h00, 8'h00, 8'h03);
        check("load3", t(), 24'h000003);
        step(0, 1, 0, 0, 0);
        check("run3", running, 1'b1);
        step(0, 0, 0, 0, 1);
        check("t02", t(), 24'h000002);
        step(0, 0, 0, 0, 1);
        check("t01", t(), 24'h000001);
        step(0, 0, 0, 0, 1);
        check("t00", t(), 24'h000000);
        check("exp_flags", {running, done, alarm}, 3'b011);
        step(0, 0, 0, 0, 1);
        check("exp_hold", {t(), done, alarm}, {24'h000000, 2'b01});
        step(0, 0, 0, 1, 0);
        check("ack", {running, alarm}, 2'b00);
        step(0, 1, 0, 0, 0);
        check("start_zero", running, 1'b0);

        // borrow chains
        preset(8'h01, 8'h00, 8'h00);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("b_010000", t(), 24'h005959);
        preset(8'h10, 8'h00, 8'h00);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("b_100000", t(), 24'h095959);
        preset(8'h00, 8'h10, 8'h00);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("b_001000", t(), 24'h000959);
        preset(8'h23, 8'h59, 8'h59);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("b_235959", t(), 24'h235958);

        // rejected loads while running at 23:59:58
        preset(8'h24, 8'h00, 8'h00);
        check("err_hour", {t(), load_err, running}, {24'h235958, 2'b11});
        step(0, 0, 0, 0, 0);
        check("err_pulse", load_err, 1'b0);
        load_hour = 8'h00; load_min = 8'h00; load_sec = 8'h5A;
        step(1, 0, 0, 0, 1);
        check("err_sec", {t(), load_err, running}, {24'h235958, 2'b11});
        preset(8'h00, 8'h60, 8'h00);
        check("err_min", {t(), load_err}, {24'h235958, 1'b1});

        // pause behaviour
        preset(8'h00, 8'h00, 8'h10);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        check("pause_tick", {t(), running}, {24'h000010, 1'b0});
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        check("paused_ticks", t(), 24'h000010);
        step(0, 1, 0, 0, 0);
        check("resume", running, 1'b1);
        step(0, 0, 0, 0, 1);
        check("resume_tick", t(), 24'h000009);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check("st_pa_both", running, 1'b0);
        step(0, 0, 0, 0, 1);
        check("still_paused", t(), 24'h000009);

        // start with tick, back-to-back ticks, load with tick
        preset(8'h00, 8'h00, 8'h05);
        step(0, 1, 0, 0, 1);
        check("start_tick", {t(), running}, {24'h000005, 1'b1});
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("b2b", t(), 24'h000002);
        load_hour = 8'h07; load_min = 8'h07; load_sec = 8'h07;
        step(1, 0, 0, 0, 1);
        check("load_tick", {t(), running}, {24'h070707, 1'b0});

        // reset mid-run
        preset(8'h05, 8'h30, 8'h00);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("pre_rst", t(), 24'h052959);
        reset = 0;
        step(0, 0, 0, 0, 1);
        check("rst_run", {t(), running, done, alarm, load_err}, {24'h000000, 4'b0000});
        reset = 1;

        // load during EXPIRED
        preset(8'h00, 8'h00, 8'h01);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("exp2", {done, alarm}, 2'b11);
        preset(8'h12, 8'h34, 8'h56);
        check("load_exp", {t(), running, alarm}, {24'h123456, 2'b00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
